// File: rtl/csr_unit_if.sv
// csr_unit_if: CSR access bus between the execute stage and csr_unit
interface csr_unit_if #(parameter int XLEN = 32);
  logic valid;
  logic [1:0] op;
  logic [11:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic illegal;
  modport master(output valid, op, addr, wdata, input rdata, illegal);
  modport slave(input valid, op, addr, wdata, output rdata, illegal);
endinterface

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with RMW ops, 64-bit counters, trap/mret and interrupt arbitration
module csr_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] HART_ID = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] MVENDORID = '0
) (
  input  logic clk,
  input  logic rst_n,
  csr_unit_if.slave csr,
  input  logic trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic mret_valid,
  input  logic retire,
  input  logic irq_soft,
  input  logic irq_timer,
  input  logic irq_ext,
  output logic irq_pending,
  output logic [XLEN-1:0] irq_cause,
  output logic redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
  logic mstatus_mie, mstatus_mpie, hit, we;
  logic [XLEN-1:0] mie_r, mtvec, mscratch, mepc, mcause, mtval, mip, rdata, nv, enabled;
  logic [63:0] mcycle, minstret, mcycle_n, minstret_n;
  assign mip = XLEN'({irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0});
  always_comb begin
    hit = 1'b1;
    rdata = '0;
    case (csr.addr)
      12'h300: rdata = XLEN'({2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0});
      12'h301: rdata = {(XLEN == 64) ? 2'b10 : 2'b01, (XLEN-2)'(9'h100)};
      12'h304: rdata = mie_r;
      12'h305: rdata = mtvec;
      12'h340: rdata = mscratch;
      12'h341: rdata = mepc;
      12'h342: rdata = mcause;
      12'h343: rdata = mtval;
      12'h344: rdata = mip;
      12'hB00, 12'hC00: rdata = XLEN'(mcycle);
      12'hB02, 12'hC02: rdata = XLEN'(minstret);
      12'hB80, 12'hC80: begin
        hit = XLEN == 32;
        rdata = hit ? XLEN'(mcycle[63:32]) : '0;
      end
      12'hB82, 12'hC82: begin
        hit = XLEN == 32;
        rdata = hit ? XLEN'(minstret[63:32]) : '0;
      end
      12'hF11: rdata = MVENDORID;
      12'hF12, 12'hF13: rdata = '0;
      12'hF14: rdata = HART_ID;
      default: hit = 1'b0;
    endcase
  end
  assign csr.rdata = rdata;
  assign csr.illegal = csr.valid & (!hit | (csr.op != 2'b00 & csr.addr[11:10] == 2'b11));
  assign we = csr.valid & (csr.op != 2'b00) & !csr.illegal & !trap_valid & !mret_valid;
  assign nv = csr.op == 2'b01 ? csr.wdata : csr.op == 2'b10 ? rdata | csr.wdata : rdata & ~csr.wdata;
  // a write to either half replaces this cycle's increment of the whole counter
  always_comb begin
    mcycle_n = mcycle + 64'd1;
    minstret_n = minstret + 64'(retire);
    if (we) begin
      if (csr.addr == 12'hB00) mcycle_n = (XLEN == 64) ? 64'(nv) : {mcycle[63:32], nv[31:0]};
      if (csr.addr == 12'hB80) mcycle_n = {nv[31:0], mcycle[31:0]};
      if (csr.addr == 12'hB02) minstret_n = (XLEN == 64) ? 64'(nv) : {minstret[63:32], nv[31:0]};
      if (csr.addr == 12'hB82) minstret_n = {nv[31:0], minstret[31:0]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_r <= '0;
      mtvec <= MTVEC_RESET & ALIGN;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
      mcycle <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle_n;
      minstret <= minstret_n;
      if (trap_valid) begin
        mepc <= trap_pc & ALIGN;
        mcause <= trap_cause;
        mtval <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie <= 1'b0;
      end else if (mret_valid) begin
        mstatus_mie <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (we) begin
        case (csr.addr)
          12'h300: begin
            mstatus_mie <= nv[3];
            mstatus_mpie <= nv[7];
          end
          12'h304: mie_r <= nv & MIE_MASK;
          12'h305: mtvec <= nv & ALIGN;
          12'h340: mscratch <= nv;
          12'h341: mepc <= nv & ALIGN;
          12'h342: mcause <= nv;
          12'h343: mtval <= nv;
          default: ;
        endcase
      end
    end
  end
  // ext outranks soft, which outranks timer
  assign enabled = mie_r & mip;
  assign irq_pending = mstatus_mie & |enabled;
  assign irq_cause = !(|enabled) ? '0 :
    {1'b1, (XLEN-1)'(enabled[11] ? 4'd11 : enabled[3] ? 4'd3 : 4'd7)};
  assign redirect_valid = trap_valid | mret_valid;
  assign redirect_pc = trap_valid ? mtvec : mepc;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed test plan plus random traffic against an address-table reference model
module tb_csr_unit;
  localparam logic [31:0] HART = 32'd3;
  localparam logic [31:0] MTVR = 32'h107;
  localparam logic [31:0] VEND = 32'h5A5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic trap_valid, mret_valid, retire, irq_soft, irq_timer, irq_ext;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic irq_pending, redirect_valid;
  logic [31:0] irq_cause, redirect_pc;
  int n_chk = 0, n_pass = 0;
  csr_unit_if #(.XLEN(32)) bus ();
  csr_unit #(.XLEN(32), .HART_ID(HART), .MTVEC_RESET(MTVR), .MVENDORID(VEND)) dut (
    .clk(clk), .rst_n(rst_n), .csr(bus),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .retire(retire),
    .irq_soft(irq_soft), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .irq_pending(irq_pending), .irq_cause(irq_cause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  // reference model: readable value and writable-bit mask per implemented address
  logic [31:0] regs [logic [11:0]];
  logic [31:0] wmask [logic [11:0]];
  logic [63:0] cyc, ins;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic def(input logic [11:0] a, input logic [31:0] v, input logic [31:0] m);
    regs[a] = v;
    wmask[a] = m;
  endtask
  task automatic model_reset();
    regs.delete();
    wmask.delete();
    def(12'h300, 32'h1800, 32'h88);
    def(12'h301, 32'h4000_0100, 0);
    def(12'h304, 0, 32'h888);
    def(12'h305, MTVR & ~32'd3, ~32'd3);
    def(12'h340, 0, '1);
    def(12'h341, 0, ~32'd3);
    def(12'h342, 0, '1);
    def(12'h343, 0, '1);
    def(12'h344, 0, 0);
    foreach (regs[a]) if (0) ;
    def(12'hB00, 0, '1); def(12'hB80, 0, '1); def(12'hB02, 0, '1); def(12'hB82, 0, '1);
    def(12'hC00, 0, 0); def(12'hC80, 0, 0); def(12'hC02, 0, 0); def(12'hC82, 0, 0);
    def(12'hF11, VEND, 0); def(12'hF12, 0, 0); def(12'hF13, 0, 0); def(12'hF14, HART, 0);
    cyc = 0;
    ins = 0;
  endtask
  function automatic logic [31:0] mip_v();
    return (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3);
  endfunction
  function automatic logic [31:0] mval(input logic [11:0] a);
    case (a)
      12'hB00, 12'hC00: return cyc[31:0];
      12'hB80, 12'hC80: return cyc[63:32];
      12'hB02, 12'hC02: return ins[31:0];
      12'hB82, 12'hC82: return ins[63:32];
      12'h344: return mip_v();
      default: return regs.exists(a) ? regs[a] : 32'd0;
    endcase
  endfunction
  function automatic logic m_illegal();
    return bus.valid && (!regs.exists(bus.addr) || (bus.op != 2'b00 && bus.addr[11:10] == 2'b11));
  endfunction
  task automatic compare();
    logic [31:0] st, en;
    st = regs[12'h300];
    en = regs[12'h304] & mip_v();
    check("rdata", bus.rdata, mval(bus.addr));
    check("illegal", 32'(bus.illegal), 32'(m_illegal()));
    check("irq_pending", 32'(irq_pending), 32'(st[3] && en != 0));
    if (en != 0) check("irq_cause", irq_cause, 32'h8000_0000 | (en[11] ? 32'd11 : en[3] ? 32'd3 : 32'd7));
    check("redirect_valid", 32'(redirect_valid), 32'(trap_valid | mret_valid));
    check("redirect_pc", redirect_pc, trap_valid ? regs[12'h305] : regs[12'h341]);
  endtask
  task automatic advance();
    logic [31:0] old, nv, st;
    logic [63:0] ncyc, nins;
    logic [11:0] a;
    a = bus.addr;
    old = mval(a);
    st = regs[12'h300];
    nv = bus.op == 2'b01 ? bus.wdata : bus.op == 2'b10 ? (old | bus.wdata) : (old & ~bus.wdata);
    ncyc = cyc + 1;
    nins = ins + 64'(retire);
    if (trap_valid) begin
      regs[12'h341] = trap_pc & ~32'd3;
      regs[12'h342] = trap_cause;
      regs[12'h343] = trap_tval;
      regs[12'h300] = 32'h1800 | (st[3] ? 32'h80 : 32'h0);
    end else if (mret_valid) begin
      regs[12'h300] = 32'h1880 | (st[7] ? 32'h8 : 32'h0);
    end else if (bus.valid && bus.op != 2'b00 && !m_illegal()) begin
      if (a == 12'hB00) ncyc = {cyc[63:32], nv};
      else if (a == 12'hB80) ncyc = {nv, cyc[31:0]};
      else if (a == 12'hB02) nins = {ins[63:32], nv};
      else if (a == 12'hB82) nins = {nv, ins[31:0]};
      else regs[a] = (regs[a] & ~wmask[a]) | (nv & wmask[a]);
    end
    cyc = ncyc;
    ins = nins;
  endtask
  task automatic set_csr(input logic v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    bus.valid = v;
    bus.op = op;
    bus.addr = a;
    bus.wdata = wd;
  endtask
  task automatic sample();
    #1;
    compare();
  endtask
  task automatic commit();
    advance();
    @(negedge clk);
    bus.valid = 1'b0;
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    retire = 1'b0;
  endtask
  task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                     input string tag = "", input logic [31:0] exp = 0);
    set_csr(1'b1, op, a, wd);
    sample();
    if (tag != "") check(tag, bus.rdata, exp);
    commit();
  endtask
  logic [11:0] pool [22] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
    12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
    12'hF11, 12'hF14, 12'h7C0, 12'h302, 12'hB01};
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    set_csr(1'b0, 2'b00, 12'h0, 0);
    {trap_valid, mret_valid, retire, irq_soft, irq_timer, irq_ext} = '0;
    {trap_cause, trap_pc, trap_tval} = '0;
    model_reset();
    repeat (2) @(negedge clk);
    set_csr(1'b1, 2'b00, 12'h300, 0);
    sample();
    check("rst_mstatus", bus.rdata, 32'h1800);
    @(negedge clk);
    rst_n = 1'b1;
    acc(2'b00, 12'hB00, 0, "mcycle_0", 0);
    acc(2'b00, 12'hB00, 0, "mcycle_1", 1);
    acc(2'b00, 12'h300, 0, "mstatus", 32'h1800);
    acc(2'b00, 12'h301, 0, "misa", 32'h4000_0100);
    acc(2'b00, 12'h305, 0, "mtvec_rst", 32'h104);
    set_csr(1'b1, 2'b00, 12'hF14, 0);
    sample();
    check("mhartid", bus.rdata, HART);
    check("mhartid_legal", 32'(bus.illegal), 0);
    commit();
    acc(2'b01, 12'h340, 32'hF0F0);
    acc(2'b00, 12'h340, 0, "rw", 32'hF0F0);
    acc(2'b10, 12'h340, 32'h000F);
    acc(2'b00, 12'h340, 0, "rs", 32'hF0FF);
    acc(2'b11, 12'h340, 32'h00F0);
    acc(2'b00, 12'h340, 0, "rc", 32'hF00F);
    set_csr(1'b1, 2'b01, 12'hF11, 32'hFFFF);
    sample();
    check("ill_f11", 32'(bus.illegal), 1);
    commit();
    set_csr(1'b1, 2'b01, 12'hC00, 32'hFFFF);
    sample();
    check("ill_c00", 32'(bus.illegal), 1);
    commit();
    acc(2'b00, 12'hF11, 0, "mvendorid_kept", VEND);
    set_csr(1'b1, 2'b00, 12'h7C0, 0);
    sample();
    check("ill_7c0", 32'(bus.illegal), 1);
    check("ill_7c0_rdata", bus.rdata, 0);
    commit();
    set_csr(1'b1, 2'b00, 12'hC00, 0);
    sample();
    check("read_c00_legal", 32'(bus.illegal), 0);
    commit();
    acc(2'b10, 12'h300, 32'h8);
    acc(2'b01, 12'h305, 32'h100);
    trap_valid = 1'b1; trap_pc = 32'h2003; trap_cause = 32'd2; trap_tval = 32'hDEAD;
    sample();
    check("trap_redirect_v", 32'(redirect_valid), 1);
    check("trap_redirect_pc", redirect_pc, 32'h100);
    commit();
    acc(2'b00, 12'h341, 0, "mepc", 32'h2000);
    acc(2'b00, 12'h300, 0, "mstatus_trap", 32'h1880);
    acc(2'b00, 12'h342, 0, "mcause", 32'd2);
    acc(2'b00, 12'h343, 0, "mtval", 32'hDEAD);
    mret_valid = 1'b1;
    sample();
    check("mret_redirect_pc", redirect_pc, 32'h2000);
    commit();
    acc(2'b00, 12'h300, 0, "mstatus_mret", 32'h1888);
    trap_valid = 1'b1; trap_pc = 32'h3001;
    sample();
    commit();
    mret_valid = 1'b1;
    sample();
    check("mret_after_trap", redirect_pc, 32'h3000);
    commit();
    acc(2'b01, 12'h304, 32'h880);
    irq_timer = 1'b1; irq_ext = 1'b1;
    set_csr(1'b1, 2'b00, 12'h344, 0);
    sample();
    check("irq_pending", 32'(irq_pending), 1);
    check("irq_cause", irq_cause, 32'h8000_000B);
    commit();
    acc(2'b11, 12'h300, 32'h8);
    set_csr(1'b1, 2'b00, 12'h300, 0);
    sample();
    check("irq_masked", 32'(irq_pending), 0);
    commit();
    irq_timer = 1'b0; irq_ext = 1'b0;
    acc(2'b01, 12'hB00, 32'hFFFF_FFFF);
    acc(2'b01, 12'hB80, 32'hFFFF_FFFF);
    acc(2'b00, 12'hB00, 0, "mcycle_ones", 32'hFFFF_FFFF);
    acc(2'b00, 12'hB80, 0, "mcycleh_wrap", 0);
    acc(2'b00, 12'hB00, 0, "mcycle_wrap", 1);
    retire = 1'b1;
    acc(2'b00, 12'h340, 0);
    retire = 1'b1;
    acc(2'b01, 12'hB02, 32'd5);
    retire = 1'b1;
    acc(2'b00, 12'h340, 0);
    acc(2'b00, 12'hB02, 0, "minstret", 32'd6);
    trap_valid = 1'b1; trap_pc = 32'h40;
    acc(2'b01, 12'h340, 32'h1234);
    acc(2'b00, 12'h340, 0, "trap_drops_write", 32'hF00F);
    for (int i = 0; i < 400; i++) begin
      set_csr($urandom_range(3) != 0, 2'($urandom), pool[$urandom_range(21)], $urandom);
      trap_valid = $urandom_range(9) == 0;
      mret_valid = $urandom_range(9) == 0;
      retire = 1'($urandom);
      {irq_soft, irq_timer, irq_ext} = 3'($urandom);
      trap_cause = $urandom; trap_pc = $urandom; trap_tval = $urandom;
      sample();
      commit();
    end
    {irq_soft, irq_timer, irq_ext} = '0;
    set_csr(1'b1, 2'b01, 12'h340, 32'hAAAA);
    #3;
    rst_n = 1'b0;
    model_reset();
    sample();
    @(negedge clk);
    set_csr(1'b1, 2'b00, 12'h305, 0);
    sample();
    @(negedge clk);
    rst_n = 1'b1;
    acc(2'b00, 12'h340, 0, "mscratch_after_rst", 0);
    acc(2'b00, 12'hB00, 0, "mcycle_after_rst", 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
